// File: rtl/load_arbiter_if.sv
// Requester and loader side bundle of the load arbiter; slave is the arbiter view,
// master is the view of whatever drives requests and the loader.
interface load_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int TILE_WIDTH = 256,
  parameter int IDX_WIDTH  = 16
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*24-1:0]      req_addr;
  logic [NUM_REQ*20-1:0]      req_len;
  logic [NUM_REQ-1:0]         resp_tile_valid;
  logic [TILE_WIDTH-1:0]      resp_tile_data;
  logic [IDX_WIDTH-1:0]       resp_tile_idx;
  logic [NUM_REQ-1:0]         resp_done;
  logic                       resp_err;
  logic                       ld_valid_in;
  logic [23:0]                ld_dram_addr;
  logic [19:0]                ld_length;
  logic [TILE_WIDTH-1:0]      ld_data_out;
  logic                       ld_tile_out;
  logic                       ld_valid_out;
  logic                       busy;
  logic [$clog2(NUM_REQ)-1:0] owner;

  modport slave (
    input  req_valid, req_addr, req_len, ld_data_out, ld_tile_out, ld_valid_out,
    output req_ready, resp_tile_valid, resp_tile_data, resp_tile_idx, resp_done, resp_err,
           ld_valid_in, ld_dram_addr, ld_length, busy, owner
  );

  modport master (
    output req_valid, req_addr, req_len, ld_data_out, ld_tile_out, ld_valid_out,
    input  req_ready, resp_tile_valid, resp_tile_data, resp_tile_idx, resp_done, resp_err,
           ld_valid_in, ld_dram_addr, ld_length, busy, owner
  );
endinterface

// File: rtl/load_arbiter.sv
// Round-robin sharing of one tile loader between NUM_REQ requesters; tiles forwarded one cycle
// after the loader strobe, done one cycle after loader completion; new requests wait while busy.
module load_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int TILE_WIDTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst,
  load_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            state_q, state_d;
  logic [OW-1:0]         last_q, last_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [23:0]           addr_q, addr_d;
  logic [19:0]           len_q, len_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [27:0]           exp_q, exp_d;
  logic [NUM_REQ-1:0]    tile_vld_q, tile_vld_d;
  logic [TILE_WIDTH-1:0] tile_dat_q, tile_dat_d;
  logic [IDX_WIDTH-1:0]  tile_idx_q, tile_idx_d;

  logic [2*NUM_REQ-1:0]  req_dbl;
  logic [NUM_REQ-1:0]    req_rot;
  logic                  found;
  logic [OW-1:0]         win;
  logic [NUM_REQ-1:0]    req_ready;

  // Rotate so that bit 0 is the requester just after the last grant.
  always_comb begin
    req_dbl = {bus.req_valid, bus.req_valid} >> ({1'b0, last_q} + 1'b1);
    req_rot = req_dbl[NUM_REQ-1:0];
    found   = 1'b0;
    win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        win   = OW'((int'(last_q) + 1 + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    tile_vld_d = '0;
    tile_dat_d = tile_dat_q;
    tile_idx_d = tile_idx_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready = NUM_REQ'(1) << win;
          owner_d   = win;
          last_d    = win;
          addr_d    = bus.req_addr[win*24 +: 24];
          len_d     = bus.req_len[win*20 +: 20];
          state_d   = (bus.req_len[win*20 +: 20] == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_BUSY;
        cnt_d   = '0;
        exp_d   = ({8'd0, len_q} * 28'(DATA_WIDTH) + 28'(TILE_WIDTH - 1)) / 28'(TILE_WIDTH);
      end
      S_BUSY: begin
        if (bus.ld_tile_out) begin
          tile_vld_d = NUM_REQ'(1) << owner_q;
          tile_dat_d = bus.ld_data_out;
          tile_idx_d = cnt_q;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        // Completion is sticky from the previous job, so it only counts here.
        if (bus.ld_valid_out) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= OW'(NUM_REQ - 1);
      owner_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      tile_vld_q <= '0;
      tile_dat_q <= '0;
      tile_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      tile_vld_q <= tile_vld_d;
      tile_dat_q <= tile_dat_d;
      tile_idx_q <= tile_idx_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.resp_tile_valid = tile_vld_q;
  assign bus.resp_tile_data  = tile_dat_q;
  assign bus.resp_tile_idx   = tile_idx_q;
  assign bus.resp_done       = (state_q == S_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.resp_err        = (state_q == S_DONE) && (len_q != '0) && (28'(cnt_q) != exp_q);
  assign bus.ld_valid_in     = (state_q == S_ISSUE);
  assign bus.ld_dram_addr    = addr_q;
  assign bus.ld_length       = len_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.owner           = owner_q;
endmodule

// File: tb/tb_load_arbiter.sv
// Bench for load_arbiter: mock tile loader over a synthetic byte memory, event monitor,
// and per-scenario tasks that compare against a request-level model.
module tb_load_arbiter;
  localparam int NR = 3;
  localparam int TW = 256;
  localparam int DW = 8;
  localparam int IW = 16;
  localparam int TB = TW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_arbiter_if #(.NUM_REQ(NR), .TILE_WIDTH(TW), .IDX_WIDTH(IW)) bus ();
  load_arbiter #(.NUM_REQ(NR), .TILE_WIDTH(TW), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [NR-1:0] vec;
    logic [TW-1:0] dat;
    int            idx;
    int            cyc;
    logic          err;
    logic [23:0]   addr;
    logic [19:0]   len;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  tile_q[$], done_q[$], start_q[$];
  int   strobe_q[$];
  int   vout_cyc = -1;
  int   ld_ovr = -1;
  ev_t  mon_e;
  logic [23:0] ld_a;
  logic [19:0] ld_l;
  int   ld_n;
  bit   ld_abort;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [TW-1:0] ld_tile(input logic [23:0] a, input logic [19:0] l, input int k);
    logic [TW-1:0] t;
    t = '0;
    for (int b = 0; b < TB; b++)
      if (k * TB + b < int'(l)) t[TW-1-8*b -: 8] = mem_byte(a + 24'(k * TB + b));
    return t;
  endfunction

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input int last, input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++) if (m[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  // Mock loader: tiles emitted with random gaps, completion sticky until the next start.
  initial begin
    bus.ld_tile_out = 1'b0;
    bus.ld_valid_out = 1'b0;
    bus.ld_data_out = '0;
    forever begin
      @(negedge clk);
      bus.ld_tile_out = 1'b0;
      if (rst) begin
        bus.ld_valid_out = 1'b0;
      end else if (bus.ld_valid_in) begin
        ld_a = bus.ld_dram_addr;
        ld_l = bus.ld_length;
        ld_n = (ld_ovr >= 0) ? ld_ovr : (int'(ld_l) * DW + TW - 1) / TW;
        bus.ld_valid_out = 1'b0;
        ld_abort = 1'b0;
        for (int k = 0; k < ld_n && !ld_abort; k++) begin
          repeat (1 + $urandom_range(0, 2)) begin
            @(negedge clk);
            bus.ld_tile_out = 1'b0;
            if (rst) ld_abort = 1'b1;
          end
          if (!ld_abort) begin
            bus.ld_tile_out = 1'b1;
            bus.ld_data_out = ld_tile(ld_a, ld_l, k);
            strobe_q.push_back(cyc);
          end
        end
        if (!ld_abort && $urandom_range(0, 1) == 1) begin
          @(negedge clk);
          bus.ld_tile_out = 1'b0;
          if (rst) ld_abort = 1'b1;
        end
        if (!ld_abort) begin
          bus.ld_valid_out = 1'b1;
          vout_cyc = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      mon_e = '{default: '0};
      mon_e.cyc = cyc;
      if (bus.ld_valid_in) begin
        mon_e.addr = bus.ld_dram_addr;
        mon_e.len = bus.ld_length;
        start_q.push_back(mon_e);
      end
      if (|bus.resp_tile_valid) begin
        mon_e.vec = bus.resp_tile_valid;
        mon_e.dat = bus.resp_tile_data;
        mon_e.idx = int'(bus.resp_tile_idx);
        tile_q.push_back(mon_e);
      end
      if (|bus.resp_done) begin
        mon_e.vec = bus.resp_done;
        mon_e.err = bus.resp_err;
        mon_e.addr = bus.ld_dram_addr;
        mon_e.len = bus.ld_length;
        done_q.push_back(mon_e);
      end
    end
  end

  task automatic clear_logs();
    tile_q.delete(); done_q.delete(); start_q.delete(); strobe_q.delete();
  endtask

  task automatic issue(input int r, input logic [23:0] a, input logic [19:0] l,
                       output int acc, output bit ok);
    @(negedge clk);
    bus.req_addr[r*24 +: 24] = a;
    bus.req_len[r*20 +: 20] = l;
    bus.req_valid[r] = 1'b1;
    ok = 1'b0;
    acc = -1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (bus.req_ready[r]) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #2;
      if (done_q.size() > 0) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({bus.req_ready, bus.resp_tile_valid, bus.resp_done, bus.resp_err, bus.ld_valid_in, bus.busy} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {bus.req_ready, bus.resp_tile_valid, bus.resp_done, bus.resp_err, bus.ld_valid_in, bus.busy}); end
    checks++; if (bus.owner !== '0) begin errors++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
    checks++; if (bus.resp_tile_data !== '0 || bus.resp_tile_idx !== '0) begin
      errors++; $display("FAIL reset_tile got idx %0d data %h want 0", bus.resp_tile_idx, bus.resp_tile_data); end
    checks++; if (bus.ld_dram_addr !== '0 || bus.ld_length !== '0) begin
      errors++; $display("FAIL reset_ld got addr %h len %0d want 0", bus.ld_dram_addr, bus.ld_length); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_jobs();
    int jr[8];
    logic [23:0] ja[8];
    logic [19:0] jl[8];
    int acc, n;
    bit ok1, ok2;
    logic [TW-1:0] expd;
    jr[0] = 0; ja[0] = 24'h000100; jl[0] = 20'd32;
    jr[1] = 1; ja[1] = 24'h000240; jl[1] = 20'd40;
    for (int j = 2; j < 8; j++) begin
      jr[j] = $urandom_range(0, NR - 1);
      ja[j] = 24'($urandom);
      jl[j] = 20'($urandom_range(1, 200));
    end
    for (int j = 0; j < 8; j++) begin
      clear_logs();
      issue(jr[j], ja[j], jl[j], acc, ok1);
      ok2 = 1'b0;
      if (ok1) wait_done(ok2);
      n = (int'(jl[j]) * DW + TW - 1) / TW;
      checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL job%0d_timeout got accept %0b done %0b want 1 1", j, ok1, ok2); end
      checks++;
      if (start_q.size() != 1) begin errors++; $display("FAIL job%0d_start got %0d pulses want 1", j, start_q.size()); end
      else if (start_q[0].addr !== ja[j] || start_q[0].len !== jl[j] || start_q[0].cyc != acc + 1) begin
        errors++; $display("FAIL job%0d_start got addr %h len %0d cyc %0d want %h %0d %0d", j,
                           start_q[0].addr, start_q[0].len, start_q[0].cyc, ja[j], jl[j], acc + 1); end
      checks++; if (tile_q.size() != n) begin errors++; $display("FAIL job%0d_tile_count got %0d want %0d", j, tile_q.size(), n); end
      for (int k = 0; k < tile_q.size() && k < n && k < strobe_q.size(); k++) begin
        expd = '0;
        for (int b = 0; b < TB; b++)
          expd = {expd[TW-9:0], (k * TB + b < int'(jl[j])) ? mem_byte(ja[j] + 24'(k * TB + b)) : 8'h00};
        checks++;
        if (tile_q[k].vec !== (3'(1) << jr[j]) || tile_q[k].idx != k || tile_q[k].dat !== expd || tile_q[k].cyc != strobe_q[k] + 1) begin
          errors++; $display("FAIL job%0d_tile%0d got vec %b idx %0d cyc %0d data %h want vec %b idx %0d cyc %0d data %h", j, k,
                             tile_q[k].vec, tile_q[k].idx, tile_q[k].cyc, tile_q[k].dat, 3'(1) << jr[j], k, strobe_q[k] + 1, expd); end
      end
      checks++;
      if (done_q.size() != 1) begin errors++; $display("FAIL job%0d_done got %0d pulses want 1", j, done_q.size()); end
      else if (done_q[0].vec !== (3'(1) << jr[j]) || done_q[0].err !== 1'b0 || done_q[0].cyc != vout_cyc + 1 ||
               done_q[0].addr !== ja[j] || done_q[0].len !== jl[j]) begin
        errors++; $display("FAIL job%0d_done got vec %b err %b cyc %0d addr %h len %0d want %b 0 %0d %h %0d", j, done_q[0].vec,
                           done_q[0].err, done_q[0].cyc, done_q[0].addr, done_q[0].len, 3'(1) << jr[j], vout_cyc + 1, ja[j], jl[j]); end
    end
  endtask

  task automatic test_round_robin();
    int exp_a[4] = '{0, 1, 2, 0};
    int got[$];
    int w, e, last;
    bit rer;
    logic [NR-1:0] rem;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < NR; r++) begin bus.req_addr[r*24 +: 24] = 24'(r * 24'h1000); bus.req_len[r*20 +: 20] = 20'd32; end
    bus.req_valid = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rer = 1'b0;
    for (int n = 0; n < 800 && got.size() < 4; n++) begin
      #1;
      if (|bus.req_ready) begin
        w = oh2i(bus.req_ready);
        got.push_back(w);
        @(negedge clk);
        if (w == 0 && !rer) rer = 1'b1; else bus.req_valid[w] = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    checks++; if (got.size() != 4) begin errors++; $display("FAIL rr_grant_count got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] != exp_a[i]) begin errors++; $display("FAIL rr_order%0d got %0d want %0d", i, got[i], exp_a[i]); end
    end
    for (int n = 0; n < 200 && bus.busy; n++) @(negedge clk);
    last = 0;
    for (int round = 0; round < 10; round++) begin
      @(negedge clk);
      bus.req_len = '0;
      rem = NR'($urandom_range(1, (1 << NR) - 1));
      bus.req_valid = rem;
      for (int n = 0; n < 40 && rem != '0; n++) begin
        #1;
        if (|bus.req_ready) begin
          w = oh2i(bus.req_ready);
          e = rr_pick(last, rem);
          checks++; if (w != e) begin errors++; $display("FAIL rr_random%0d got %0d want %0d", round, w, e); end
          last = e;
          rem[w] = 1'b0;
          @(negedge clk);
          bus.req_valid[w] = 1'b0;
        end
        @(negedge clk);
      end
      checks++; if (rem != '0) begin errors++; $display("FAIL rr_random%0d_stall got pending %b want 0", round, rem); end
      bus.req_valid = '0;
    end
  endtask

  task automatic test_zero_len();
    int acc;
    bit ok;
    clear_logs();
    issue(2, 24'h000300, 20'd0, acc, ok);
    repeat (4) @(negedge clk);
    #2;
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept got 0 want 1"); end
    checks++;
    if (done_q.size() != 1) begin errors++; $display("FAIL zero_done got %0d pulses want 1", done_q.size()); end
    else if (done_q[0].vec !== 3'b100 || done_q[0].err !== 1'b0 || done_q[0].cyc != acc + 1) begin
      errors++; $display("FAIL zero_done got vec %b err %b cyc %0d want 100 0 %0d", done_q[0].vec, done_q[0].err, done_q[0].cyc, acc + 1); end
    checks++; if (start_q.size() != 0 || tile_q.size() != 0) begin
      errors++; $display("FAIL zero_loader got starts %0d tiles %0d want 0 0", start_q.size(), tile_q.size()); end
  endtask

  task automatic test_mismatch();
    int ovr_t[3] = '{1, 3, -1};
    bit err_t[3] = '{1'b1, 1'b1, 1'b0};
    int acc, nt;
    bit ok1, ok2;
    for (int t = 0; t < 3; t++) begin
      ld_ovr = ovr_t[t];
      clear_logs();
      issue(t % NR, 24'h000400, 20'd64, acc, ok1);
      ok2 = 1'b0;
      if (ok1) wait_done(ok2);
      nt = (ovr_t[t] >= 0) ? ovr_t[t] : 2;
      checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL mismatch%0d_timeout got %0b %0b want 1 1", t, ok1, ok2); end
      checks++;
      if (done_q.size() != 1) begin errors++; $display("FAIL mismatch%0d_done got %0d pulses want 1", t, done_q.size()); end
      else if (done_q[0].err !== err_t[t]) begin errors++; $display("FAIL mismatch%0d_err got %b want %b", t, done_q[0].err, err_t[t]); end
      checks++; if (tile_q.size() != nt) begin errors++; $display("FAIL mismatch%0d_tiles got %0d want %0d", t, tile_q.size(), nt); end
    end
    ld_ovr = -1;
  endtask

  task automatic test_reset_mid_job();
    int acc;
    bit ok;
    clear_logs();
    issue(0, 24'h000500, 20'd96, acc, ok);
    for (int n = 0; n < 100 && tile_q.size() == 0; n++) begin @(negedge clk); #2; end
    checks++; if (tile_q.size() == 0) begin errors++; $display("FAIL rstmid_first_tile got 0 tiles want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({bus.resp_tile_valid, bus.resp_done, bus.resp_err, bus.ld_valid_in, bus.busy} !== '0 ||
                  bus.resp_tile_data !== '0 || bus.resp_tile_idx !== '0 || bus.ld_dram_addr !== '0) begin
      errors++; $display("FAIL rstmid_outputs got ctrl %b idx %0d addr %h want 0", {bus.resp_tile_valid, bus.resp_done,
                         bus.resp_err, bus.ld_valid_in, bus.busy}, bus.resp_tile_idx, bus.ld_dram_addr); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    checks++; if (done_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_done got done %0d busy %b want 0 0", done_q.size(), bus.busy); end
    @(negedge clk);
    bus.req_len = '0;
    bus.req_valid = 3'b101;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_regrant got %b want 001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_len = '0;
    test_reset();
    test_jobs();
    test_round_robin();
    test_zero_len();
    test_mismatch();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion within 40000 cycles want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
